// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: mode encodings and the clog2 helper shared by stream_mux and rr_arbiter.
package stream_mux_pkg;
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; scans from ptr+1 upward with wrap.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int SW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [SW-1:0] g,
    output logic          gv
);
    logic [SW-1:0] idx;

    // Walk the scan order backwards so the channel closest to ptr+1 wins.
    always_comb begin
        g = '0;
        idx = '0;
        for (int k = N; k >= 1; k--) begin
            idx = SW'((int'(ptr) + k) % N);
            if (req[idx]) g = idx;
        end
    end

    assign gv = |req;
endmodule

// File: rtl/stream_mux.sv
// stream_mux: N-channel registered valid/ready mux, fixed select or round-robin.
// Define STREAM_MUX_LOCK_EN to hold the grant on one channel until its in_last beat.
module stream_mux
    import stream_mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           e,
    input  logic           mode,
    input  logic [SW-1:0]  s,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    input  logic [N-1:0]   in_last,
    output logic [N-1:0]   in_ready,
    output logic [W-1:0]   Y,
    output logic           y_valid,
    input  logic           y_ready,
    output logic           y_last,
    output logic [SW-1:0]  y_ch
);
    if (SW != clog2(N)) begin : g_sw_check
        $error("stream_mux: SW must equal clog2(N)");
    end

    logic [SW-1:0] ptr, g, rr_g;
    logic          gv, rr_gv, acc;

    rr_arbiter #(.N(N), .SW(SW)) u_arb (
        .req (in_valid),
        .ptr (ptr),
        .g   (rr_g),
        .gv  (rr_gv)
    );

`ifdef STREAM_MUX_LOCK_EN
    logic          lock;
    logic [SW-1:0] lock_ch;

    always_ff @(posedge clk) begin
        if (rst) begin
            lock    <= 1'b0;
            lock_ch <= '0;
        end else if (acc) begin
            lock    <= ~in_last[g];
            lock_ch <= g;
        end
    end
`endif

    // Out-of-range fixed selects never grant.
    always_comb begin
        g  = mode == MODE_RR ? rr_g : s;
        gv = mode == MODE_RR ? rr_gv : (int'(s) < N) & in_valid[s];
`ifdef STREAM_MUX_LOCK_EN
        if (lock) begin
            g  = lock_ch;
            gv = in_valid[lock_ch];
        end
`endif
    end

    assign acc      = ~rst & e & (~y_valid | y_ready) & gv;
    assign in_ready = acc ? (N'(1) << g) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            Y       <= '0;
            y_valid <= 1'b0;
            y_last  <= 1'b0;
            y_ch    <= '0;
            ptr     <= SW'(N - 1);
        end else if (acc) begin
            Y       <= in_data[int'(g) * W +: W];
            y_valid <= 1'b1;
            y_last  <= in_last[g];
            y_ch    <= g;
            if (mode == MODE_RR) ptr <= g;
        end else if (y_ready) begin
            y_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_stream_mux.sv
// tb_stream_mux: directed and randomized checks of stream_mux against a behavioural model.
module tb_stream_mux;
    localparam int N = 4;
    localparam int W = 8;
    localparam int SW = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           e = 1'b1;
    logic           mode = 1'b0;
    logic [SW-1:0]  s = '0;
    logic [N*W-1:0] in_data = '0;
    logic [N-1:0]   in_valid = '1;
    logic [N-1:0]   in_last = '1;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   Y;
    logic           y_valid;
    logic           y_ready = 1'b1;
    logic           y_last;
    logic [SW-1:0]  y_ch;

    int tests = 0;
    int fails = 0;

    // Model state, starting at reset values.
    logic [W-1:0] m_y = '0;
    bit           m_v = 0;
    bit           m_last = 0;
    int           m_ch = 0;
    int           m_ptr = N - 1;
    bit           m_lock = 0;
    int           m_lock_ch = 0;
    logic [N-1:0] er;

    stream_mux #(.N(N), .W(W), .SW(SW)) dut (
        .clk(clk), .rst(rst), .e(e), .mode(mode), .s(s),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .Y(Y), .y_valid(y_valid), .y_ready(y_ready),
        .y_last(y_last), .y_ch(y_ch)
    );

    always #5 clk = ~clk;

    // Predicts in_ready for the current inputs and advances the model across the coming edge.
    task automatic model(output logic [N-1:0] rdy);
        int g;
        bit gv, acc;
        g = 0;
        gv = 0;
        if (m_lock) begin
            g = m_lock_ch;
            gv = in_valid[g];
        end else if (mode == 1'b0) begin
            g = int'(s);
            gv = g < N && in_valid[g];
        end else begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (in_valid[c] && !gv) begin
                    g = c;
                    gv = 1;
                end
            end
        end
        acc = !rst && e && (!m_v || y_ready) && gv;
        rdy = acc ? N'(1 << g) : '0;
        if (rst) begin
            m_y = '0; m_v = 0; m_last = 0; m_ch = 0; m_ptr = N - 1; m_lock = 0; m_lock_ch = 0;
        end else if (acc) begin
            m_y = in_data[g*W +: W];
            m_last = in_last[g];
            m_ch = g;
            m_v = 1;
            if (mode) m_ptr = g;
`ifdef STREAM_MUX_LOCK_EN
            m_lock = !in_last[g];
            m_lock_ch = g;
`endif
        end else if (y_ready) begin
            m_v = 0;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rst = 1; in_valid = '1; e = 1; y_ready = 1; mode = 0; s = 2; in_data = 32'hDEADBEEF;
            #1 model(er);
            tests++; if (in_ready !== 4'b0000) begin fails++; $display("FAIL reset_ready got %b want 0000", in_ready); end
            @(posedge clk); #1;
            tests++; if (y_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", y_valid); end
            tests++; if (Y !== 8'h00) begin fails++; $display("FAIL reset_Y got %h want 00", Y); end
            tests++; if (y_ch !== 2'd0) begin fails++; $display("FAIL reset_ch got %0d want 0", y_ch); end
        end
    endtask

    task automatic test_fixed();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rst = 0; mode = 0; s = 2; in_valid = 4'b1111; in_last = '1; y_ready = 1; e = 1;
            in_data = {8'h11, 8'hA5, 8'h22, 8'(i)};
            #1 model(er);
            tests++; if (in_ready !== 4'b0100) begin fails++; $display("FAIL fixed_ready got %b want 0100", in_ready); end
            @(posedge clk); #1;
            tests++; if (Y !== 8'hA5 || y_ch !== 2'd2 || y_valid !== 1'b1) begin
                fails++; $display("FAIL fixed_out got Y=%h ch=%0d v=%b want Y=a5 ch=2 v=1", Y, y_ch, y_valid);
            end
        end
    endtask

    task automatic test_rr();
        int exp_ch[4] = '{0, 1, 3, 0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mode = 1; in_valid = 4'b1011; in_last = '1; y_ready = 1; e = 1;
            in_data = $urandom;
            #1 model(er);
            tests++; if (in_ready !== er || in_ready !== N'(1 << exp_ch[i])) begin
                fails++; $display("FAIL rr_ready got %b want %b", in_ready, N'(1 << exp_ch[i]));
            end
            @(posedge clk); #1;
            tests++; if (y_ch !== SW'(exp_ch[i]) || Y !== m_y) begin
                fails++; $display("FAIL rr_grant got ch=%0d Y=%h want ch=%0d Y=%h", y_ch, Y, exp_ch[i], m_y);
            end
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        mode = 0; s = 1; in_valid = 4'b0010; in_last = '1; y_ready = 1; e = 1;
        in_data = {8'h00, 8'h00, 8'h3C, 8'h00};
        #1 model(er);
        @(posedge clk); #1;
        tests++; if (Y !== 8'h3C) begin fails++; $display("FAIL bp_load got %h want 3c", Y); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            y_ready = 0; in_data = {8'h00, 8'h00, 8'h77, 8'h00};
            #1 model(er);
            tests++; if (in_ready !== 4'b0000) begin fails++; $display("FAIL bp_ready got %b want 0000", in_ready); end
            @(posedge clk); #1;
            tests++; if (Y !== 8'h3C || y_ch !== 2'd1 || y_valid !== 1'b1) begin
                fails++; $display("FAIL bp_hold got Y=%h ch=%0d v=%b want Y=3c ch=1 v=1", Y, y_ch, y_valid);
            end
        end
        @(negedge clk);
        y_ready = 1;
        #1 model(er);
        tests++; if (in_ready !== 4'b0010) begin fails++; $display("FAIL bp_resume_ready got %b want 0010", in_ready); end
        @(posedge clk); #1;
        tests++; if (Y !== 8'h77 || y_valid !== 1'b1) begin fails++; $display("FAIL bp_next got Y=%h v=%b want Y=77 v=1", Y, y_valid); end
        @(negedge clk);
        in_valid = 4'b0000;
        #1 model(er);
        @(posedge clk); #1;
        tests++; if (y_valid !== 1'b0) begin fails++; $display("FAIL bp_nodup got %b want 0", y_valid); end
    endtask

    task automatic test_enable();
        @(negedge clk);
        mode = 0; s = 1; in_valid = 4'b0010; y_ready = 1; e = 1;
        #1 model(er);
        @(posedge clk); #1;
        @(negedge clk);
        e = 0;
        #1 model(er);
        tests++; if (in_ready !== 4'b0000) begin fails++; $display("FAIL en_ready got %b want 0000", in_ready); end
        @(posedge clk); #1;
        tests++; if (y_valid !== 1'b0) begin fails++; $display("FAIL en_drain got %b want 0", y_valid); end
        @(negedge clk);
        e = 1;
        #1 model(er);
        tests++; if (in_ready !== 4'b0010) begin fails++; $display("FAIL en_resume_ready got %b want 0010", in_ready); end
        @(posedge clk); #1;
        tests++; if (y_valid !== 1'b1) begin fails++; $display("FAIL en_resume got %b want 1", y_valid); end
    endtask

`ifdef STREAM_MUX_LOCK_EN
    task automatic test_lock();
        logic [N-1:0] lasts[4] = '{4'b1111, 4'b1101, 4'b1101, 4'b1111};
        int exp_ch[5] = '{0, 1, 1, 1, 2};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            mode = 1; e = 1; y_ready = 1; in_data = $urandom;
            in_valid = i == 0 ? 4'b0001 : 4'b0111;
            in_last = i < 4 ? lasts[i] : 4'b1111;
            #1 model(er);
            @(posedge clk); #1;
            tests++; if (y_ch !== SW'(exp_ch[i])) begin fails++; $display("FAIL lock_grant got %0d want %0d", y_ch, exp_ch[i]); end
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            rst = $urandom_range(0, 49) == 0;
            e = $urandom_range(0, 7) != 0;
            mode = 1'($urandom);
            s = SW'($urandom);
            in_valid = N'($urandom);
            in_last = N'($urandom);
            in_data = $urandom;
            y_ready = $urandom_range(0, 3) != 0;
            #1 model(er);
            tests++; if (in_ready !== er) begin fails++; $display("FAIL rand_ready got %b want %b", in_ready, er); end
            @(posedge clk); #1;
            tests++; if (y_valid !== m_v || Y !== m_y || y_last !== m_last || y_ch !== SW'(m_ch)) begin
                fails++;
                $display("FAIL rand_out got v=%b Y=%h l=%b ch=%0d want v=%b Y=%h l=%b ch=%0d",
                         y_valid, Y, y_last, y_ch, m_v, m_y, m_last, m_ch);
            end
        end
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_rr();
        test_backpressure();
        test_enable();
`ifdef STREAM_MUX_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/stream_mux.md
# stream_mux

Parametrised N-channel, W-bit registered stream multiplexer, successor to the combinational `mux21`. It selects one of N valid/ready input channels, either by a fixed select or by round-robin arbitration, and places the chosen beat in a single output register stage. It sits between multiple producer channels and one consumer in the datapath, and keeps the enable semantics of `mux21`.

## Interface
- `N`, 4: number of input channels, 2..16.
- `W`, 8: data width per channel.
- `SW`, 2: select/channel-index width; must equal clog2(N).

- `clk` input, 1 bit: sole clock; all state updates on its rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `e` input, 1 bit: enable. At 0, no new beat is accepted; the output may still drain.
- `mode` input, 1 bit: 0 = fixed select, 1 = round-robin.
- `s` input, SW bits: channel select in fixed mode.
- `in_data` input, N*W bits: channel i occupies bits [i*W +: W].
- `in_valid` input, N bits: per-channel valid.
- `in_last` input, N bits: per-channel end-of-packet marker.
- `in_ready` output, N bits: per-channel ready, combinational, one-hot or zero.
- `Y` output, W bits: registered output data.
- `y_valid` output, 1 bit: output beat valid.
- `y_ready` input, 1 bit: consumer ready.
- `y_last` output, 1 bit: registered copy of the granted channel's `in_last`.
- `y_ch` output, SW bits: index of the channel that supplied `Y`.

## Operation
- **Output slot.** The output slot is free when `y_valid`=0 or `y_ready`=1.
- **Accept condition.** `acc = e & slot_free & grant_valid`.
- **Fixed grant (`mode`=0).** `g = s`; `grant_valid = in_valid[s]`. Values of `s` ≥ N give `grant_valid`=0.
- **Round-robin grant (`mode`=1).** Scan channels from `ptr+1` upward, wrapping N-1→0. `g` is the first channel with `in_valid`=1. `grant_valid` = |`in_valid`.
- **Ready.** `in_ready[g] = acc`; all other bits are 0.
- **On `acc`.** `Y`←data[g], `y_last`←`in_last[g]`, `y_ch`←g, `y_valid`←1. In mode 1, `ptr`←g.
- **Drain only.** If there is no `acc` and `y_ready`=1, then `y_valid`←0. `Y`, `y_ch` and `y_last` hold their values.
- **Full slot.** While `y_valid`=1 and `y_ready`=0, the output registers are stable and all `in_ready` bits are 0.
- **Selection changes.** Changes to `mode` or `s` take effect at the next accept decision. No partial beats are possible.
- **`ptr` in fixed mode.** `ptr` is unchanged in fixed mode.

## Timing
- **Reset values.** `Y`=0, `y_valid`=0, `y_last`=0, `y_ch`=0, `ptr`=N-1 (so the first round-robin grant scans from channel 0), lock state cleared.
- **Reset mid-operation.** A beat held in the output register is discarded. `in_ready` is 0 during the reset cycle.
- **Latency.** 1 cycle from input handshake to `y_valid`.
- **Throughput.** 1 beat/cycle when `y_ready` is held at 1.
- **Simultaneous events.** Drain and accept in the same cycle replace the beat; `y_valid` stays 1.
- **Ready path.** `in_ready` depends combinationally on `y_ready`, `e`, `mode`, `s` and `in_valid`. It never depends on `in_data`.

## Configuration
- **`STREAM_MUX_LOCK_EN` defined:** packet lock is compiled in.
  - Accepting a beat with `in_last[g]`=0 sets `lock`=1 and `lock_ch`=g.
  - While locked, the grant is forced to `lock_ch` regardless of `mode`/`s`. `grant_valid = in_valid[lock_ch]`.
  - Accepting a beat with `in_last`=1 clears `lock`.
  - `ptr` is updated on every accepted beat as normal.
- **Undefined:** no lock state. Arbitration is per beat, and `in_last` is passed through to `y_last` only.

## Structure
- The shared package/include holds:
  - the mode encodings `MODE_FIXED`=0 and `MODE_RR`=1;
  - a clog2 constant function used to check `SW`.
- Sub-module `rr_arbiter`: N-bit request vector and SW-bit pointer in, SW-bit grant index and grant-valid out. Purely combinational.
- The top level holds the output register, `ptr` and the lock state.

## Test plan
1. **Reset.** `rst`=1 for 2 cycles with all inputs valid → `y_valid`=0, `Y`=0, `y_ch`=0, `in_ready`=0000.
2. **Fixed mode.** `mode`=0, `s`=2, `in_valid`=1111, ch2 data=8'hA5, `y_ready`=1 → `in_ready`=0100; next cycle `Y`=A5, `y_ch`=2; repeats every cycle.
3. **Round-robin.** `mode`=1, `in_valid`=1011, `y_ready`=1 → grants in order ch0, ch1, ch3, ch0 on consecutive cycles; ch2 is never granted.
4. **Backpressure.** Output holds `Y`=3C, `y_ready`=0 for 3 cycles → `Y`, `y_ch` stable, `in_ready`=0000. Then `y_ready`=1 → the next beat appears one cycle later with no beat lost or duplicated.
5. **Enable.** `e`=0 with `y_valid`=1 and `y_ready`=1 → `y_valid` falls the next cycle, `in_ready`=0000. Setting `e`=1 resumes accepts.
6. **Lock (with `STREAM_MUX_LOCK_EN`).** `mode`=1, ch1 sends a 3-beat packet (`in_last`=0,0,1) while ch0 and ch2 are valid → 3 consecutive `y_ch`=1, then the grant moves to ch2.
